serial_shift_receiver: RTL
==========================

# serial_shift_receiver

Serial-in, parallel-out word receiver for the low-speed bit-serial link driven by our parallel-load shift transmitters, which send LSB first. It resynchronises the external bit clock, data and frame lines into `clk`, detects rising bit-clock edges and assembles N-bit words. Each completed word goes into a one-entry output buffer with a valid/read handshake. Overrun and framing errors are reported as sticky flags. It sits between the board-level serial pins and the register/SRAM side of the SoC.

## Interface
- N, default 8: word width in bits (N >= 2).
- clk  in  1  system clock; all state updates on its rising edge.
- reset_p  in  1  reset, synchronous, active-high.
- sclk  in  1  serial bit clock from the transmitter; asynchronous to `clk`. Data is sampled on its rising edge.
- sdata  in  1  serial data, LSB first; asynchronous to `clk`.
- frame_n  in  1  frame enable, active-low; asynchronous to `clk`.
- rd_en  in  1  consumer read strobe; pops the output buffer.
- clear_err  in  1  clears both sticky error flags.
- data_out  out  N  last completed word.
- valid  out  1  `data_out` holds an unread word.
- overrun  out  1  sticky: a completed word was dropped because the buffer was full.
- frame_err  out  1  sticky: the frame ended with a partial word.

## Operation
- Synchroniser: `sclk`, `sdata` and `frame_n` each pass through an identical 2-FF chain, giving `sclk_s`, `sdata_s` and `frame_n_s`.
- A third register on `sclk_s` gives `sclk_d`. The rising-edge pulse `rise = sclk_s & ~sclk_d` is one `clk` wide.
- FSM states: IDLE and SHIFT.
  - IDLE: `bit_cnt` = 0 and the shift register is cleared. When `frame_n_s` = 0, go to SHIFT.
  - SHIFT, on `rise`: `shreg <= {sdata_s, shreg[N-1:1]}` and `bit_cnt` increments.
  - SHIFT, on `rise` with `bit_cnt == N-1`: the word `{sdata_s, shreg[N-1:1]}` is complete and `bit_cnt` wraps to 0. The FSM stays in SHIFT, so back-to-back words within one frame are supported.
  - SHIFT, when `frame_n_s` = 1: go to IDLE. If `bit_cnt != 0` after this cycle's `rise` has been processed, set `frame_err` and discard the partial word.
  - If `rise` and frame deassertion occur in the same cycle, the bit is taken first. A word completed by that bit is delivered, with no `frame_err`.
- Output buffer:
  - Word complete and (`valid` = 0 or `rd_en` = 1): load `data_out` and set `valid` = 1.
  - Word complete, `valid` = 1 and `rd_en` = 0: drop the new word, keep `data_out`, set `overrun` = 1.
  - `rd_en` with `valid` = 1 and no load: `valid` goes to 0 and `data_out` holds its value.
  - `rd_en` with `valid` = 0: ignored.
- Error flags: `clear_err` clears both flags. If `clear_err` and a new error event occur in the same cycle, the set wins.
- Reset (synchronous), state afterwards:
  - FSM in IDLE, `bit_cnt` = 0, `shreg` = 0.
  - `data_out` = 0, `valid` = 0, `overrun` = 0, `frame_err` = 0.
  - Synchroniser and edge registers at idle levels: sclk chain 0, frame_n chain 1, sdata chain 0, so no spurious edge or frame start follows reset.
  - Reset mid-word discards the partial word without flagging `frame_err`.

## Timing
- Latency: a pin-level `sclk` rise sampled at clk edge k gives `rise` = 1 during cycle k+2. The shift, or the shift plus output load for the last bit, happens at edge k+2. `valid` is seen high 3 `clk` cycles after the final `sclk` rise.
- `sclk` high and low phases must each be >= 3 `clk` periods.
- `sdata` must be stable >= 2 `clk` periods before and after each `sclk` rise.
- Frame timing: `frame_n` falls >= 3 `clk` periods before the first `sclk` rise, and rises >= 3 `clk` periods after the last.
- `rd_en` acts in the cycle it is sampled. `valid` drops the next cycle unless a new word loads in that same cycle.
- Throughput: one word per N bit periods, with no dead cycles between words in a frame.

## Test plan
- Frame carrying 0xA5 LSB first, no read: `data_out` = 0xA5 and `valid` = 1 exactly 3 clk after the 8th `sclk` rise; pulse `rd_en` -> `valid` = 0 next cycle, `data_out` still 0xA5.
- One frame with 0x3C then 0xC3 back-to-back, each read once `valid` is seen: both words delivered in order; `overrun` = 0 and `frame_err` = 0.
- Send 0x11, do not read, then send 0x22: `data_out` stays 0x11, `valid` = 1, `overrun` = 1; pulse `clear_err` -> `overrun` = 0.
- Word loaded with `rd_en` = 1 in the same cycle while `valid` = 1: `data_out` = new word, `valid` stays 1, `overrun` = 0.
- Frame aborted after 5 bits: `frame_err` = 1 and `valid` stays 0; the next full frame with 0x5A yields `data_out` = 0x5A.
- Assert `reset_p` for 1 cycle after 4 bits of a word: all outputs 0 and no `frame_err`; the following frame with 0xFF yields `data_out` = 0xFF.

Source files
------------

// File: rtl/serial_shift_receiver.sv
// serial_shift_receiver: resynchronised LSB-first serial-to-parallel word receiver
// with a one-entry output buffer and sticky overrun/framing error flags.
module serial_shift_receiver #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_p,
    input  logic         sclk,
    input  logic         sdata,
    input  logic         frame_n,
    input  logic         rd_en,
    input  logic         clear_err,
    output logic [N-1:0] data_out,
    output logic         valid,
    output logic         overrun,
    output logic         frame_err
);
    localparam int CW = $clog2(N);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nx;
    logic [1:0] sclk_q, sdata_q, frame_q;
    logic sclk_s, sdata_s, frame_n_s, sclk_d, rise;
    logic [N-1:0] shreg, shreg_nx, shifted;
    logic [CW-1:0] bit_cnt, cnt_nx;
    logic done, ferr_set, load, drop;
    assign sclk_s    = sclk_q[1];
    assign sdata_s   = sdata_q[1];
    assign frame_n_s = frame_q[1];
    assign rise      = sclk_s & ~sclk_d;
    assign shifted   = {sdata_s, shreg[N-1:1]};
    assign load      = done & (~valid | rd_en);
    assign drop      = done & valid & ~rd_en;
    // Reset values are the idle line levels so no false edge or frame start follows.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            sclk_q  <= '0;
            sdata_q <= '0;
            frame_q <= '1;
            sclk_d  <= 1'b0;
        end else begin
            sclk_q  <= {sclk_q[0], sclk};
            sdata_q <= {sdata_q[0], sdata};
            frame_q <= {frame_q[0], frame_n};
            sclk_d  <= sclk_s;
        end
    end
    always_ff @(posedge clk) begin
        if (reset_p)
            state <= IDLE;
        else
            state <= state_nx;
    end
    // A bit arriving with frame deassertion is shifted before the partial-word test.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = bit_cnt;
        done     = 1'b0;
        ferr_set = 1'b0;
        if (state == IDLE) begin
            shreg_nx = '0;
            cnt_nx   = '0;
            state_nx = frame_n_s ? IDLE : SHIFT;
        end else begin
            if (rise) begin
                done     = bit_cnt == CW'(N - 1);
                shreg_nx = shifted;
                cnt_nx   = done ? '0 : bit_cnt + 1'b1;
            end
            if (frame_n_s) begin
                state_nx = IDLE;
                ferr_set = cnt_nx != '0;
                shreg_nx = '0;
                cnt_nx   = '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset_p) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            shreg     <= shreg_nx;
            bit_cnt   <= cnt_nx;
            data_out  <= load ? shifted : data_out;
            valid     <= load | (valid & ~rd_en);
            overrun   <= drop | (overrun & ~clear_err);
            frame_err <= ferr_set | (frame_err & ~clear_err);
        end
    end
endmodule
